// File: rtl/bidir_serial_ctrl.sv
// Half-duplex single-wire serial transceiver feeding a bidirectional pad buffer.
// Define BIDIR_SERIAL_PARITY_EN to insert an even-parity bit before the stop bit.
module bidir_serial_ctrl #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int TURN_CYCLES  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_err,
   output logic              busy,
   output logic              pad_t,
   output logic              pad_i,
   input  logic              pad_o
);
   localparam int TMAX = (CLKS_PER_BIT > TURN_CYCLES) ? CLKS_PER_BIT : TURN_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int IW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TURN_END = TW'(TURN_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

   typedef enum logic [3:0] {
      IDLE, TX_START, TX_DATA,
`ifdef BIDIR_SERIAL_PARITY_EN
      TX_PAR,
`endif
      TX_STOP, TURN, RX_START, RX_DATA,
`ifdef BIDIR_SERIAL_PARITY_EN
      RX_PAR,
`endif
      RX_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [IW-1:0]       idx_q, idx_d, idx_nxt;
   logic [DATA_W-1:0]   tx_word_q, tx_word_d;
   logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
   logic [DATA_W:0]     rx_cat;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                rx_err_q, rx_err_d;
   logic                pad_t_q, pad_t_d;
   logic                pad_i_q, pad_i_d;
   logic                sync1_q, sync2_q, line_prev_q;
   logic                line_fall;
`ifdef BIDIR_SERIAL_PARITY_EN
   logic                rx_par_q, rx_par_d;
   logic                par_err_q, par_err_d;
`endif

   // Line idles high, so the synchroniser and edge flop reset to 1 to avoid a false start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         line_prev_q <= 1'b1;
      end else begin
         sync1_q     <= pad_o;
         sync2_q     <= sync1_q;
         line_prev_q <= sync2_q;
      end
   end

   assign line_fall = line_prev_q & ~sync2_q;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q + TW'(1);
      idx_d      = idx_q;
      idx_nxt    = idx_q + IW'(1);
      tx_word_d  = tx_word_q;
      rx_shift_d = rx_shift_q;
      rx_cat     = {sync2_q, rx_shift_q};
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_err_d   = rx_err_q;
      pad_t_d    = pad_t_q;
      pad_i_d    = pad_i_q;
`ifdef BIDIR_SERIAL_PARITY_EN
      rx_par_d   = rx_par_q;
      par_err_d  = par_err_q;
`endif
      case (state_q)
         IDLE: begin
            timer_d = '0;
            idx_d   = '0;
            if (tx_valid && tx_ready) begin
               tx_word_d = tx_data;
               pad_t_d   = 1'b1;
               pad_i_d   = 1'b0;
               state_d   = TX_START;
            end else if (line_fall) begin
`ifdef BIDIR_SERIAL_PARITY_EN
               rx_par_d = 1'b0;
`endif
               state_d = RX_START;
            end
         end
         TX_START: if (timer_q == BIT_END) begin
            timer_d = '0;
            pad_i_d = tx_word_q[0];
            state_d = TX_DATA;
         end
         TX_DATA: if (timer_q == BIT_END) begin
            timer_d = '0;
            if (idx_q == LAST_IDX) begin
`ifdef BIDIR_SERIAL_PARITY_EN
               pad_i_d = ^tx_word_q;
               state_d = TX_PAR;
`else
               pad_i_d = 1'b1;
               state_d = TX_STOP;
`endif
            end else begin
               idx_d   = idx_nxt;
               pad_i_d = tx_word_q[idx_nxt];
            end
         end
`ifdef BIDIR_SERIAL_PARITY_EN
         TX_PAR: if (timer_q == BIT_END) begin
            timer_d = '0;
            pad_i_d = 1'b1;
            state_d = TX_STOP;
         end
`endif
         TX_STOP: if (timer_q == BIT_END) begin
            timer_d = '0;
            pad_t_d = 1'b0;
            pad_i_d = 1'b1;
            state_d = TURN;
         end
         TURN: if (timer_q == TURN_END) state_d = IDLE;
         RX_START: if (timer_q == HALF_END) begin
            timer_d = '0;
            state_d = sync2_q ? IDLE : RX_DATA;
         end
         RX_DATA: if (timer_q == BIT_END) begin
            timer_d    = '0;
            rx_shift_d = rx_cat[DATA_W:1];
`ifdef BIDIR_SERIAL_PARITY_EN
            rx_par_d   = rx_par_q ^ sync2_q;
`endif
            if (idx_q == LAST_IDX) begin
`ifdef BIDIR_SERIAL_PARITY_EN
               state_d = RX_PAR;
`else
               state_d = RX_STOP;
`endif
            end else begin
               idx_d = idx_nxt;
            end
         end
`ifdef BIDIR_SERIAL_PARITY_EN
         RX_PAR: if (timer_q == BIT_END) begin
            timer_d   = '0;
            par_err_d = rx_par_q ^ sync2_q;
            state_d   = RX_STOP;
         end
`endif
         // rx_valid is presented while still in RX_STOP; IDLE (and tx_ready) follows it.
         RX_STOP: begin
            if (rx_valid_q) begin
               state_d = IDLE;
            end else if (timer_q == BIT_END) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rx_shift_q;
`ifdef BIDIR_SERIAL_PARITY_EN
               rx_err_d   = ~sync2_q | par_err_q;
`else
               rx_err_d   = ~sync2_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         idx_q      <= '0;
         tx_word_q  <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         pad_t_q    <= 1'b0;
         pad_i_q    <= 1'b1;
`ifdef BIDIR_SERIAL_PARITY_EN
         rx_par_q   <= 1'b0;
         par_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         tx_word_q  <= tx_word_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
         pad_t_q    <= pad_t_d;
         pad_i_q    <= pad_i_d;
`ifdef BIDIR_SERIAL_PARITY_EN
         rx_par_q   <= rx_par_d;
         par_err_q  <= par_err_d;
`endif
      end
   end

   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_err   = rx_err_q;
   assign pad_t    = pad_t_q;
   assign pad_i    = pad_i_q;

endmodule
